// File: rtl/rs_berlekamp_massey.sv
// Inversionless Berlekamp-Massey key-equation solver for RS decoding.
// GF(2^8), poly 0x11D; one iteration per clock, 2*T_LEN iterations per codeword.
package gf_pkg;
    localparam int SYMB_WIDTH = 8;
    localparam logic [SYMB_WIDTH-1:0] GF_POLY = 8'h1D;

    function automatic logic [SYMB_WIDTH-1:0] gf_mult(
        input logic [SYMB_WIDTH-1:0] a,
        input logic [SYMB_WIDTH-1:0] b
    );
        logic [SYMB_WIDTH-1:0] p;
        p = '0;
        for (int i = SYMB_WIDTH-1; i >= 0; i--) begin
            p = {p[SYMB_WIDTH-2:0], 1'b0} ^ (p[SYMB_WIDTH-1] ? GF_POLY : '0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction
endpackage

module rs_berlekamp_massey
    import gf_pkg::*;
#(
    parameter  int T_LEN = 8,
    localparam int L_W   = $clog2(2*T_LEN+1)
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [2*T_LEN-1:0][SYMB_WIDTH-1:0]    syndromes,
    input  logic                                  syndromes_vld,
    output logic                                  s_ready,
    output logic [T_LEN:0][SYMB_WIDTH-1:0]        lambda,
    output logic [L_W-1:0]                        lambda_deg,
    output logic                                  err_free,
    output logic                                  uncorrectable,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic                                  overflow_err
);
    localparam int NS  = 2*T_LEN;
    localparam int R_W = $clog2(NS);
    localparam int SW  = SYMB_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [NS-1:0][SW-1:0]    syn_q, syn_d;
    logic [T_LEN:0][SW-1:0]   lam_q, lam_d, lam_nx;
    logic [T_LEN-1:0][SW-1:0] b_q, b_d, b_nx;
    logic [SW-1:0]            gamma_q, gamma_d, gamma_nx;
    logic [L_W-1:0]           len_q, len_d, len_nx;
    logic [R_W-1:0]           r_q, r_d;
    logic                     zero_q, zero_d;
    logic [T_LEN:0][SW-1:0]   lam_o_q, lam_o_d;
    logic [L_W-1:0]           deg_q, deg_d;
    logic                     ef_q, ef_d;
    logic                     unc_q, unc_d;
    logic                     ovf_q, ovf_d;
    logic [SW-1:0]            disc;
    logic [L_W-1:0]           r_ext;
    logic                     upd;

    assign s_ready       = (state_q == IDLE);
    assign m_tvalid      = (state_q == DONE);
    assign lambda        = lam_o_q;
    assign lambda_deg    = deg_q;
    assign err_free      = ef_q;
    assign uncorrectable = unc_q;
    assign overflow_err  = ovf_q;
    assign r_ext         = L_W'(r_q);

    always_comb begin
        disc = '0;
        for (int i = 0; i <= T_LEN; i++) begin
            if (L_W'(i) <= r_ext) begin
                disc = disc ^ gf_mult(lam_q[i], syn_q[R_W'(r_ext - L_W'(i))]);
            end
        end
        upd = (disc != '0) && ({len_q, 1'b0} <= {1'b0, r_ext});

        // x*B only needs T_LEN stored terms: B[T_LEN] would fall off the top.
        lam_nx[0] = gf_mult(gamma_q, lam_q[0]);
        for (int i = 1; i <= T_LEN; i++) begin
            lam_nx[i] = gf_mult(gamma_q, lam_q[i]) ^ gf_mult(disc, b_q[i-1]);
        end

        b_nx[0] = '0;
        for (int i = 1; i < T_LEN; i++) begin
            b_nx[i] = b_q[i-1];
        end
        gamma_nx = gamma_q;
        len_nx   = len_q;
        if (upd) begin
            b_nx     = lam_q[T_LEN-1:0];
            gamma_nx = disc;
            len_nx   = r_ext + L_W'(1) - len_q;
        end
    end

    always_comb begin
        state_d = state_q;
        syn_d   = syn_q;
        lam_d   = lam_q;
        b_d     = b_q;
        gamma_d = gamma_q;
        len_d   = len_q;
        r_d     = r_q;
        zero_d  = zero_q;
        lam_o_d = lam_o_q;
        deg_d   = deg_q;
        ef_d    = ef_q;
        unc_d   = unc_q;
        ovf_d   = ovf_q | (syndromes_vld & ~s_ready);

        unique case (state_q)
            IDLE: begin
                if (syndromes_vld) begin
                    syn_d    = syndromes;
                    lam_d    = '0;
                    lam_d[0] = SW'(1);
                    b_d      = '0;
                    b_d[0]   = SW'(1);
                    gamma_d  = SW'(1);
                    len_d    = '0;
                    r_d      = '0;
                    zero_d   = (syndromes == '0);
                    state_d  = CALC;
                end
            end
            CALC: begin
                lam_d   = lam_nx;
                b_d     = b_nx;
                gamma_d = gamma_nx;
                len_d   = len_nx;
                r_d     = r_q + R_W'(1);
                if (r_q == R_W'(NS-1)) begin
                    lam_o_d = lam_nx;
                    deg_d   = len_nx;
                    ef_d    = zero_q;
                    unc_d   = (len_nx > L_W'(T_LEN));
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m_tready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            syn_q   <= '0;
            lam_q   <= '0;
            b_q     <= '0;
            gamma_q <= '0;
            len_q   <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
            lam_o_q <= '0;
            deg_q   <= '0;
            ef_q    <= 1'b0;
            unc_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            syn_q   <= syn_d;
            lam_q   <= lam_d;
            b_q     <= b_d;
            gamma_q <= gamma_d;
            len_q   <= len_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            lam_o_q <= lam_o_d;
            deg_q   <= deg_d;
            ef_q    <= ef_d;
            unc_q   <= unc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_rs_berlekamp_massey.sv
// Bench for rs_berlekamp_massey: error patterns turned into syndromes,
// result locator checked for roots, degree, flags and handshake timing.
module tb_rs_berlekamp_massey;
    localparam int T  = 8;
    localparam int NS = 16;

    typedef logic [NS-1:0][7:0] syn_t;
    typedef logic [T:0][7:0]    lam_t;

    typedef struct {
        int nerr;
        int loc[8];
        int val[8];
        int exp_deg;
        bit exp_ef;
        bit exp_unc;
    } vec_t;

    logic       aclk;
    logic       areset;
    syn_t       syndromes;
    logic       syndromes_vld;
    logic       s_ready;
    lam_t       lambda;
    logic [4:0] lambda_deg;
    logic       err_free;
    logic       uncorrectable;
    logic       m_tvalid;
    logic       m_tready;
    logic       overflow_err;

    rs_berlekamp_massey #(.T_LEN(T)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .syndromes     (syndromes),
        .syndromes_vld (syndromes_vld),
        .s_ready       (s_ready),
        .lambda        (lambda),
        .lambda_deg    (lambda_deg),
        .err_free      (err_free),
        .uncorrectable (uncorrectable),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .overflow_err  (overflow_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] gexp[255];
    int         glog[256];
    vec_t       tbl[7];

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic syn_t calc_syn(input vec_t v);
        syn_t s;
        s = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < v.nerr; j++) begin
                s[i] = s[i] ^ gmul(8'(v.val[j]), gexp[(v.loc[j] * i) % 255]);
            end
        end
        return s;
    endfunction

    function automatic logic [7:0] eval_lam(input lam_t l, input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] xp;
        acc = 8'h00;
        xp  = 8'h01;
        for (int k = 0; k <= T; k++) begin
            acc = acc ^ gmul(l[k], xp);
            xp  = gmul(xp, x);
        end
        return acc;
    endfunction

    task automatic send(input syn_t s);
        check("s_ready_before_send", s_ready, 1);
        syndromes     = s;
        syndromes_vld = 1'b1;
        @(posedge aclk);
        #1;
        syndromes_vld = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (m_tvalid !== 1'b1 && lat < 64) begin
            @(posedge aclk);
            #1;
            lat++;
        end
        check("done_within_bound", m_tvalid, 1);
    endtask

    task automatic accept();
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
    endtask

    initial begin
        int   lat;
        syn_t s;
        lam_t e_one;
        lam_t e_unit;

        areset        = 1'b1;
        syndromes     = '0;
        syndromes_vld = 1'b0;
        m_tready      = 1'b0;

        gexp[0] = 8'h01;
        for (int i = 1; i < 255; i++) gexp[i] = xtime(gexp[i-1]);
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;

        e_unit    = '0;
        e_unit[0] = 8'h01;
        e_one     = e_unit;
        e_one[1]  = 8'h01;

        tbl[0] = '{1, '{5, 0, 0, 0, 0, 0, 0, 0},
                   '{'h37, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0};
        tbl[1] = '{2, '{0, 254, 0, 0, 0, 0, 0, 0},
                   '{'h01, 'h80, 0, 0, 0, 0, 0, 0}, 2, 0, 0};
        tbl[2] = '{3, '{3, 100, 200, 0, 0, 0, 0, 0},
                   '{'h11, 'h22, 'h33, 0, 0, 0, 0, 0}, 3, 0, 0};
        tbl[3] = '{4, '{1, 2, 3, 4, 0, 0, 0, 0},
                   '{'hFF, 'h01, 'hA5, 'h5A, 0, 0, 0, 0}, 4, 0, 0};
        tbl[4] = '{5, '{10, 20, 30, 40, 50, 0, 0, 0},
                   '{'h02, 'h04, 'h08, 'h10, 'h20, 0, 0, 0}, 5, 0, 0};
        tbl[5] = '{6, '{7, 17, 77, 177, 227, 250, 0, 0},
                   '{'hC3, 'h3C, 'h99, 'h66, 'hE1, 'h1E, 0, 0}, 6, 0, 0};
        tbl[6] = '{8, '{0, 31, 62, 93, 124, 155, 186, 217},
                   '{'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08}, 8, 0, 0};

        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_lambda", lambda, 0);
        check("rst_deg", lambda_deg, 0);
        check("rst_err_free", err_free, 0);
        check("rst_unc", uncorrectable, 0);
        check("rst_overflow", overflow_err, 0);

        // All-zero syndromes: locator stays 1.
        send('0);
        wait_done(lat);
        check("zero_latency", lat, 16);
        check("zero_lambda", lambda, e_unit);
        check("zero_deg", lambda_deg, 0);
        check("zero_err_free", err_free, 1);
        check("zero_unc", uncorrectable, 0);
        check("zero_s_ready", s_ready, 0);
        accept();
        check("zero_back_idle", m_tvalid, 0);

        // Error value 1 at alpha^0: every syndrome is 1, Lambda = 1 + x.
        for (int i = 0; i < NS; i++) s[i] = 8'h01;
        send(s);
        wait_done(lat);
        check("one_latency", lat, 16);
        check("one_lambda", lambda, e_one);
        check("one_deg", lambda_deg, 1);
        check("one_err_free", err_free, 0);
        check("one_unc", uncorrectable, 0);
        accept();

        for (int k = 0; k < 7; k++) begin
            send(calc_syn(tbl[k]));
            wait_done(lat);
            check($sformatf("v%0d_latency", k), lat, 16);
            check($sformatf("v%0d_deg", k), lambda_deg, tbl[k].exp_deg);
            check($sformatf("v%0d_err_free", k), err_free, tbl[k].exp_ef);
            check($sformatf("v%0d_unc", k), uncorrectable, tbl[k].exp_unc);
            check($sformatf("v%0d_lam0_nonzero", k), lambda[0] != 8'h00, 1);
            for (int j = 0; j < tbl[k].nerr; j++) begin
                check($sformatf("v%0d_root%0d", k, j),
                      eval_lam(lambda, gexp[(255 - tbl[k].loc[j]) % 255]), 0);
            end
            for (int i = tbl[k].nerr + 1; i <= T; i++) begin
                check($sformatf("v%0d_hi%0d_zero", k, i), lambda[i], 0);
            end
            accept();
        end

        // Only S[8] nonzero: register length jumps to 9, locator truncated to 1.
        s    = '0;
        s[8] = 8'h01;
        send(s);
        wait_done(lat);
        check("s8_deg", lambda_deg, 9);
        check("s8_unc", uncorrectable, 1);
        check("s8_err_free", err_free, 0);
        check("s8_lambda", lambda, e_unit);
        accept();

        // Only S[15] nonzero: length 16 must fit the degree field.
        s     = '0;
        s[15] = 8'h01;
        send(s);
        wait_done(lat);
        check("s15_deg", lambda_deg, 16);
        check("s15_unc", uncorrectable, 1);
        check("s15_lambda", lambda, e_unit);
        accept();

        // Hold result in DONE for 5 cycles, strobe a vector meanwhile.
        for (int i = 0; i < NS; i++) s[i] = 8'h01;
        send(s);
        wait_done(lat);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_lambda", c), lambda, e_one);
            check($sformatf("hold%0d_deg", c), lambda_deg, 1);
            check($sformatf("hold%0d_valid", c), m_tvalid, 1);
            check($sformatf("hold%0d_s_ready", c), s_ready, 0);
            if (c == 1) begin
                syndromes     = '0;
                syndromes_vld = 1'b1;
            end
            @(posedge aclk);
            #1;
            syndromes_vld = 1'b0;
        end
        check("hold_overflow", overflow_err, 1);
        check("hold_lambda_after", lambda, e_one);
        accept();
        send('0);
        wait_done(lat);
        check("after_ovf_lambda", lambda, e_unit);
        check("after_ovf_deg", lambda_deg, 0);
        check("after_ovf_err_free", err_free, 1);
        check("after_ovf_sticky", overflow_err, 1);
        accept();

        // Reset while r == 7.
        for (int i = 0; i < NS; i++) s[i] = 8'h01;
        send(s);
        repeat (7) @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_lambda", lambda, 0);
        check("midrst_overflow", overflow_err, 0);
        send(s);
        wait_done(lat);
        check("midrst_next_latency", lat, 16);
        check("midrst_next_lambda", lambda, e_one);
        check("midrst_next_deg", lambda_deg, 1);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
